// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Releases NUM_DOMAINS active-low resets one at a time, STAGGER cycles apart,
//   once the PLL lock has been synchronised and held high for LOCK_STABLE
//   cycles. Lock loss or a soft reset request reasserts every reset at once;
//   lock loss also bumps a saturating event counter.
//
//   Optional feature macro: PLL_RESTART_EN
//     When defined, a lock timeout counter runs in WAIT_LOCK/STABLE and, on
//     expiry, pulses pll_rst_o for PLL_RST_CYCLES cycles before waiting again.
//     When undefined, pll_rst_o is tied low and WAIT_LOCK waits indefinitely.
//
// Ports
//   clk              single clock (PLL reference clock)
//   resetn           async active-low reset
//   pll_locked_i     PLL lock, asynchronous to clk
//   soft_rst_i       synchronous request to re-run the sequence
//   rst_n_o          per-domain reset, active low, bit 0 released first
//   all_ready_o      high while every domain is released (RUN)
//   lock_loss_cnt_o  saturating count of lock-loss events
//   state_o          0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN, 4 PLL_RST
//   pll_rst_o        PLL reset request
module pll_reset_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 3,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned STAGGER        = 16,
  parameter int unsigned CNT_W          = 8
`ifdef PLL_RESTART_EN
  ,
  parameter int unsigned LOCK_TIMEOUT   = 1000000,
  parameter int unsigned PLL_RST_CYCLES = 16
`endif
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   pll_locked_i,
  input  logic                   soft_rst_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   all_ready_o,
  output logic [CNT_W-1:0]       lock_loss_cnt_o,
  output logic [2:0]             state_o,
  output logic                   pll_rst_o
);

  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam int unsigned GW = $clog2(STAGGER + 1);
  localparam int unsigned IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [SW-1:0]    STAB_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [GW-1:0]    STAG_LAST = GW'(STAGGER - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

`ifdef PLL_RESTART_EN
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned PW = $clog2(PLL_RST_CYCLES + 1);
  // to_cnt lags the elapsed edge count by one, so matching LOCK_TIMEOUT
  // enters PLL_RST on edge LOCK_TIMEOUT+1 after the count started.
  localparam logic [TW-1:0] TO_HIT   = TW'(LOCK_TIMEOUT);
  localparam logic [PW-1:0] PRC_LAST = PW'(PLL_RST_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    PLL_RST   = 3'd4
  } state_t;

  state_t        state;
  logic          sync1;
  logic          lock_s;
  logic [SW-1:0] stab_cnt;
  logic [GW-1:0] stag_cnt;
  logic [IW-1:0] idx;

`ifdef PLL_RESTART_EN
  logic [TW-1:0] to_cnt;
  logic [PW-1:0] prc_cnt;
  logic          timeout;
  assign timeout = (to_cnt == TO_HIT);
`else
  assign pll_rst_o = 1'b0;
`endif

  assign state_o = state;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_locked_i;
      lock_s <= sync1;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= WAIT_LOCK;
      rst_n_o         <= '0;
      all_ready_o     <= 1'b0;
      lock_loss_cnt_o <= '0;
      stab_cnt        <= '0;
      stag_cnt        <= '0;
      idx             <= '0;
`ifdef PLL_RESTART_EN
      to_cnt          <= '0;
      prc_cnt         <= '0;
      pll_rst_o       <= 1'b0;
`endif
    end else begin
`ifdef PLL_RESTART_EN
      // Timeout accumulates while waiting for a usable lock.
      if (state == WAIT_LOCK || state == STABLE) begin
        to_cnt <= to_cnt + TW'(1);
      end
`endif
      case (state)
        WAIT_LOCK: begin
`ifdef PLL_RESTART_EN
          if (timeout) begin
            state     <= PLL_RST;
            pll_rst_o <= 1'b1;
            prc_cnt   <= '0;
            to_cnt    <= '0;
          end else
`endif
          if (lock_s) begin
            state    <= STABLE;
            stab_cnt <= '0;
          end
        end

        STABLE: begin
          if (!lock_s || soft_rst_i) begin
            state <= WAIT_LOCK;
`ifdef PLL_RESTART_EN
          end else if (timeout) begin
            state     <= PLL_RST;
            pll_rst_o <= 1'b1;
            prc_cnt   <= '0;
            to_cnt    <= '0;
`endif
          end else if (stab_cnt == STAB_LAST) begin
            // First domain goes out the edge after the lock has qualified.
            rst_n_o     <= NUM_DOMAINS'(1);
            idx         <= IW'(1);
            stag_cnt    <= '0;
            state       <= (NUM_DOMAINS > 1) ? RELEASE : RUN;
            all_ready_o <= (NUM_DOMAINS == 1);
`ifdef PLL_RESTART_EN
            to_cnt      <= '0;
`endif
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
          end
        end

        RELEASE, RUN: begin
          if (!lock_s || soft_rst_i) begin
            // All domains drop together; only a real lock loss is counted.
            state       <= WAIT_LOCK;
            rst_n_o     <= '0;
            all_ready_o <= 1'b0;
            idx         <= '0;
            stag_cnt    <= '0;
            if (!lock_s && lock_loss_cnt_o != CNT_MAX) begin
              lock_loss_cnt_o <= lock_loss_cnt_o + CNT_W'(1);
            end
          end else if (state == RELEASE) begin
            if (stag_cnt == STAG_LAST) begin
              rst_n_o  <= rst_n_o | (NUM_DOMAINS'(1) << idx);
              stag_cnt <= '0;
              if (idx == IDX_LAST) begin
                state       <= RUN;
                all_ready_o <= 1'b1;
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              stag_cnt <= stag_cnt + GW'(1);
            end
          end
        end

`ifdef PLL_RESTART_EN
        PLL_RST: begin
          if (prc_cnt == PRC_LAST) begin
            state     <= WAIT_LOCK;
            pll_rst_o <= 1'b0;
          end else begin
            prc_cnt <= prc_cnt + PW'(1);
          end
        end
`endif

        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule
